// File: rtl/instr_cache_pkg.sv
// Shared widths and state encoding for the direct-mapped instruction cache.
// Address split is {tag, index, offset}, with the offset in the low bits.
package icache_pkg;

  localparam int WORD_SIZE = 16;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  function automatic int offset_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int index_w(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int tag_w(input int word_size, input int num_lines, input int line_words);
    return word_size - $clog2(num_lines) - $clog2(line_words);
  endfunction

endpackage

// File: rtl/instr_cache_if.sv
// Fetch-side and memory-side signals of the instruction cache.
// master = CPU fetch stage plus word memory; slave = the cache.
interface instr_cache_if #(
  parameter int WORD_SIZE = icache_pkg::WORD_SIZE
);

  logic                 cpu_req;
  logic [WORD_SIZE-1:0] cpu_addr;
  logic                 cpu_ready;
  logic [WORD_SIZE-1:0] cpu_data;
  logic                 i_readM;
  logic                 i_writeM;
  logic [WORD_SIZE-1:0] i_address;
  logic [WORD_SIZE-1:0] i_data;

  modport master (
    output cpu_req, cpu_addr, i_data,
    input  cpu_ready, cpu_data, i_readM, i_writeM, i_address
  );

  modport slave (
    input  cpu_req, cpu_addr, i_data,
    output cpu_ready, cpu_data, i_readM, i_writeM, i_address
  );

endinterface

// File: rtl/instr_cache_line_store.sv
// Line data plus tag/valid arrays: async read, sync write, valid bits cleared by reset or flush.
// Data and tags are never cleared; only the valid bits decide whether a line is usable.
module icache_line_store
  import icache_pkg::*;
#(
  parameter int  WORD_SIZE  = icache_pkg::WORD_SIZE,
  parameter int  LINE_WORDS = 4,
  parameter int  NUM_LINES  = 8,
  localparam int OW = offset_w(LINE_WORDS),
  localparam int IW = index_w(NUM_LINES),
  localparam int TW = tag_w(WORD_SIZE, NUM_LINES, LINE_WORDS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic [IW-1:0]        rd_index,
  input  logic [OW-1:0]        rd_offset,
  output logic                 rd_valid,
  output logic [TW-1:0]        rd_tag,
  output logic [WORD_SIZE-1:0] rd_data,
  input  logic                 wr_en,
  input  logic [IW-1:0]        wr_index,
  input  logic [OW-1:0]        wr_offset,
  input  logic [WORD_SIZE-1:0] wr_data,
  input  logic                 set_valid,
  input  logic [TW-1:0]        set_tag
);

  logic [NUM_LINES-1:0] valid;
  logic [TW-1:0]        tag_mem  [NUM_LINES];
  logic [WORD_SIZE-1:0] data_mem [NUM_LINES][LINE_WORDS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= '0;
    end else if (flush) begin
      valid <= '0;
    end else if (set_valid) begin
      valid[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem[wr_index][wr_offset] <= wr_data;
    end
    if (set_valid) begin
      tag_mem[wr_index] <= set_tag;
    end
  end

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[rd_index][rd_offset];

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped read-only I-cache: hits answer in the request cycle, misses fill the line over
// LINE_WORDS+1 cycles of 1-cycle memory reads and then replay as a hit; no stall beyond cpu_ready=0.
module instr_cache
  import icache_pkg::*;
#(
  parameter int WORD_SIZE  = icache_pkg::WORD_SIZE,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  instr_cache_if.slave bus,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);

  localparam int OW = offset_w(LINE_WORDS);
  localparam int IW = index_w(NUM_LINES);
  localparam int TW = tag_w(WORD_SIZE, NUM_LINES, LINE_WORDS);
  localparam int CW = $clog2(LINE_WORDS + 1);

  state_t                  state;
  logic [CW-1:0]           fill_k;
  logic [WORD_SIZE-OW-1:0] line_base;
  logic                    read_q;
  logic [WORD_SIZE-1:0]    addr_q;

  logic [TW-1:0]        req_tag;
  logic [IW-1:0]        req_index;
  logic [OW-1:0]        req_offset;
  logic                 rd_valid;
  logic [TW-1:0]        rd_tag;
  logic [WORD_SIZE-1:0] rd_data;
  logic                 hit;
  logic                 miss;
  logic                 fill_wr;
  logic                 fill_last;
  logic [CW-1:0]        k_next;
  logic [OW-1:0]        next_offset;
  logic [OW-1:0]        wr_offset;

  assign req_tag    = bus.cpu_addr[WORD_SIZE-1 -: TW];
  assign req_index  = bus.cpu_addr[OW +: IW];
  assign req_offset = bus.cpu_addr[OW-1:0];

  assign hit  = (state == IDLE) && bus.cpu_req && !flush && rd_valid && (rd_tag == req_tag);
  assign miss = (state == IDLE) && bus.cpu_req && !flush && !hit;

  // Memory data lags the address by one cycle, so fill cycle k delivers word k-1.
  assign fill_wr     = (state == FILL) && (fill_k != '0) && !flush;
  assign fill_last   = (state == FILL) && (fill_k == CW'(LINE_WORDS)) && !flush;
  assign wr_offset   = OW'(fill_k - CW'(1));
  assign k_next      = fill_k + CW'(1);
  assign next_offset = (k_next >= CW'(LINE_WORDS)) ? OW'(LINE_WORDS - 1) : k_next[OW-1:0];

  icache_line_store #(
    .WORD_SIZE  (WORD_SIZE),
    .LINE_WORDS (LINE_WORDS),
    .NUM_LINES  (NUM_LINES)
  ) u_store (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .rd_index  (req_index),
    .rd_offset (req_offset),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_data   (rd_data),
    .wr_en     (fill_wr),
    .wr_index  (line_base[0 +: IW]),
    .wr_offset (wr_offset),
    .wr_data   (bus.i_data),
    .set_valid (fill_last),
    .set_tag   (line_base[WORD_SIZE-OW-1 -: TW])
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      fill_k    <= '0;
      line_base <= '0;
      read_q    <= 1'b0;
      addr_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss) begin
            state     <= FILL;
            fill_k    <= '0;
            line_base <= bus.cpu_addr[WORD_SIZE-1:OW];
            read_q    <= 1'b1;
            addr_q    <= {bus.cpu_addr[WORD_SIZE-1:OW], {OW{1'b0}}};
          end
        end
        FILL: begin
          if (flush || (fill_k == CW'(LINE_WORDS))) begin
            state  <= IDLE;
            fill_k <= '0;
            read_q <= 1'b0;
            addr_q <= '0;
          end else begin
            fill_k <= k_next;
            addr_q <= {line_base, next_offset};
          end
        end
        default: begin
          state  <= IDLE;
          read_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit && (hit_count != 16'hFFFF)) begin
        hit_count <= hit_count + 16'd1;
      end
      if (miss && (miss_count != 16'hFFFF)) begin
        miss_count <= miss_count + 16'd1;
      end
    end
  end

  assign bus.cpu_ready = hit;
  assign bus.cpu_data  = hit ? rd_data : '0;
  assign bus.i_readM   = read_q;
  assign bus.i_writeM  = 1'b0;
  assign bus.i_address = addr_q;

endmodule

// File: tb/tb_instr_cache.sv
// Directed bench for instr_cache with a 1-cycle registered memory returning addr ^ 16'hA5A5.
// Inputs change 1ns after the rising edge; outputs are checked before the next edge.
module tb_instr_cache;

  logic        clk;
  logic        reset;
  logic        flush;
  logic [15:0] hit_count;
  logic [15:0] miss_count;
  logic [15:0] mem_q;
  int          n_tests;
  int          n_fail;

  instr_cache_if #(.WORD_SIZE(16)) bus ();

  instr_cache dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .bus        (bus),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.i_readM) mem_q <= bus.i_address ^ 16'hA5A5;
  end
  assign bus.i_data = bus.i_readM ? mem_q : 16'h0000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Request a line that is not resident, follow the fill and the replayed hit.
  task automatic access_miss(input logic [15:0] a, input logic [15:0] exp_miss);
    logic [15:0] base;
    logic [15:0] exp_a;
    base = {a[15:2], 2'b00};
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = a;
    #1;
    check("miss_ready", bus.cpu_ready, 0);
    tick();
    check("miss_count", miss_count, exp_miss);
    for (int k = 0; k < 5; k++) begin
      exp_a = base + 16'((k < 3) ? k : 3);
      check("fill_readM", bus.i_readM, 1);
      check("fill_addr", bus.i_address, exp_a);
      tick();
    end
    check("replay_ready", bus.cpu_ready, 1);
    check("replay_data", bus.cpu_data, a ^ 16'hA5A5);
    tick();
    bus.cpu_req = 1'b0;
    #1;
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    reset        = 1'b1;
    flush        = 1'b0;
    bus.cpu_req  = 1'b0;
    bus.cpu_addr = 16'h0000;
    #12;
    check("rst_ready", bus.cpu_ready, 0);
    check("rst_readM", bus.i_readM, 0);
    check("rst_addr", bus.i_address, 0);
    check("rst_data", bus.cpu_data, 0);
    check("rst_hits", hit_count, 0);
    check("rst_misses", miss_count, 0);
    check("writeM", bus.i_writeM, 0);
    reset = 1'b0;
    tick();

    // Cold miss on 0x0023, then the whole line hits back to back.
    access_miss(16'h0023, 16'd1);
    check("hits_after_cold", hit_count, 1);
    bus.cpu_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.cpu_addr = 16'h0020 + 16'(i);
      #1;
      check("seq_ready", bus.cpu_ready, 1);
      check("seq_data", bus.cpu_data, (16'h0020 + 16'(i)) ^ 16'hA5A5);
      check("seq_no_read", bus.i_readM, 0);
      tick();
    end
    bus.cpu_req = 1'b0;
    check("seq_hits", hit_count, 5);
    check("seq_misses", miss_count, 1);

    // Conflict on index 0: 0x0043 evicts 0x0023 and vice versa.
    access_miss(16'h0043, 16'd2);
    access_miss(16'h0023, 16'd3);
    check("conflict_hits", hit_count, 7);

    // Flush with a request on a resident line: no hit, no miss, no fill.
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 16'h0023;
    flush        = 1'b1;
    #1;
    check("flush_ready", bus.cpu_ready, 0);
    bus.cpu_req = 1'b0;
    tick();
    flush = 1'b0;
    check("flush_misses", miss_count, 3);
    check("flush_hits", hit_count, 7);
    check("flush_readM", bus.i_readM, 0);
    access_miss(16'h0023, 16'd4);

    // Flush during fill cycle k=2 aborts the fill; the line stays invalid.
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 16'h0055;
    tick();
    check("abort_misses", miss_count, 5);
    tick();
    tick();
    bus.cpu_req = 1'b0;
    flush       = 1'b1;
    #1;
    check("abort_readM_during", bus.i_readM, 1);
    tick();
    flush = 1'b0;
    check("abort_readM_after", bus.i_readM, 0);
    check("abort_addr_after", bus.i_address, 0);
    access_miss(16'h0055, 16'd6);
    check("abort_hits", hit_count, 9);

    // Reset during fill cycle k=3.
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 16'h0066;
    tick();
    tick();
    tick();
    tick();
    check("pre_reset_addr", bus.i_address, 16'h0067);
    reset       = 1'b1;
    bus.cpu_req = 1'b0;
    #1;
    check("midfill_rst_readM", bus.i_readM, 0);
    check("midfill_rst_addr", bus.i_address, 0);
    check("midfill_rst_hits", hit_count, 0);
    check("midfill_rst_misses", miss_count, 0);
    tick();
    reset = 1'b0;
    access_miss(16'h0066, 16'd1);
    check("post_reset_hits", hit_count, 1);

    // Hit counter saturation on the resident line at 0x0064.
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 16'h0064;
    repeat (16'hFFFD) tick();
    check("sat_near", hit_count, 16'hFFFE);
    repeat (3) tick();
    check("sat_hits", hit_count, 16'hFFFF);
    check("sat_ready", bus.cpu_ready, 1);
    check("sat_misses", miss_count, 1);
    bus.cpu_req = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
